// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data_memory port: round-robin (or fixed
// R0 priority when DMEM_ARB_FIXED_PRIO_EN is defined), one outstanding read.
//
// Handshake: a requester raises i_rX_req with stable fields and holds them until
// o_rX_gnt is seen high (combinational, same cycle). The grant cycle is the issue
// cycle. A read's data returns RD_LAT cycles later as a one-cycle o_rX_rvalid pulse.
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_r0_req,
  input  logic              i_r0_we,
  input  logic [ADDR_W-1:0] i_r0_addr,
  input  logic [DATA_W-1:0] i_r0_wdata,
  output logic              o_r0_gnt,
  output logic              o_r0_rvalid,
  output logic [DATA_W-1:0] o_r0_rdata,
  input  logic              i_r1_req,
  input  logic              i_r1_we,
  input  logic [ADDR_W-1:0] i_r1_addr,
  input  logic [DATA_W-1:0] i_r1_wdata,
  output logic              o_r1_gnt,
  output logic              o_r1_rvalid,
  output logic [DATA_W-1:0] o_r1_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_dbg_state
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] LAT_RELOAD = 2'(RD_LAT - 1);

  state_t     state_q, state_d;
  logic [1:0] lat_cnt_q, lat_cnt_d;
  logic       rd_owner_q, rd_owner_d;

  logic arb_en;
  logic rd_done;
  logic pick_r0;
  logic gnt0, gnt1;
  logic issue_rd;

  // The read completion cycle doubles as an arbitration cycle so issue overlaps it.
  assign rd_done = !i_rst && (state_q == ST_RD_WAIT) && (lat_cnt_q == 2'd0);
  assign arb_en  = !i_rst && ((state_q == ST_IDLE) || rd_done);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign pick_r0 = 1'b1;
`else
  logic rr_last_q, rr_last_d;

  // rr_last_q==1 means R1 won last, so R0 takes the next tie.
  assign pick_r0 = rr_last_q;

  always_comb begin
    rr_last_d = rr_last_q;
    if (gnt0) begin
      rr_last_d = 1'b0;
    end else if (gnt1) begin
      rr_last_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`endif

  always_comb begin
    gnt0     = arb_en && i_r0_req && (!i_r1_req || pick_r0);
    gnt1     = arb_en && i_r1_req && !gnt0;
    issue_rd = (gnt0 && !i_r0_we) || (gnt1 && !i_r1_we);
  end

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    rd_owner_d = rd_owner_q;
    case (state_q)
      ST_IDLE: begin
        lat_cnt_d = 2'd0;
      end
      ST_RD_WAIT: begin
        if (lat_cnt_q != 2'd0) begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        lat_cnt_d = 2'd0;
      end
    endcase
    if (issue_rd) begin
      state_d    = ST_RD_WAIT;
      lat_cnt_d  = LAT_RELOAD;
      rd_owner_d = gnt1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      lat_cnt_q  <= 2'd0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    o_mem_en    = gnt0 || gnt1;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (gnt0) begin
      o_mem_we    = i_r0_we;
      o_mem_addr  = i_r0_addr;
      o_mem_wdata = i_r0_wdata;
    end else if (gnt1) begin
      o_mem_we    = i_r1_we;
      o_mem_addr  = i_r1_addr;
      o_mem_wdata = i_r1_wdata;
    end
  end

  // Read data is a combinational pass-through, zeroed for the non-owner.
  always_comb begin
    o_r0_gnt    = gnt0;
    o_r1_gnt    = gnt1;
    o_r0_rvalid = rd_done && !rd_owner_q;
    o_r1_rvalid = rd_done && rd_owner_q;
    o_r0_rdata  = o_r0_rvalid ? i_mem_rdata : '0;
    o_r1_rdata  = o_r1_rvalid ? i_mem_rdata : '0;
    o_dbg_state = state_q;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: three instances with RD_LAT=1,2,3 share
// one stimulus stream; each step checks the instance whose latency it targets.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata, mem_rdata;

  logic        gnt0 [3];
  logic        gnt1 [3];
  logic        rv0 [3];
  logic        rv1 [3];
  logic        mem_en [3];
  logic        mem_we [3];
  logic        dbg [3];
  logic [31:0] rdata0 [3];
  logic [31:0] rdata1 [3];
  logic [31:0] maddr [3];
  logic [31:0] mwdata [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(g + 1)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_r0_req(r0_req), .i_r0_we(r0_we), .i_r0_addr(r0_addr), .i_r0_wdata(r0_wdata),
      .o_r0_gnt(gnt0[g]), .o_r0_rvalid(rv0[g]), .o_r0_rdata(rdata0[g]),
      .i_r1_req(r1_req), .i_r1_we(r1_we), .i_r1_addr(r1_addr), .i_r1_wdata(r1_wdata),
      .o_r1_gnt(gnt1[g]), .o_r1_rvalid(rv1[g]), .o_r1_rdata(rdata1[g]),
      .o_mem_en(mem_en[g]), .o_mem_we(mem_we[g]), .o_mem_addr(maddr[g]),
      .o_mem_wdata(mwdata[g]), .i_mem_rdata(mem_rdata), .o_dbg_state(dbg[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic chk_quiet(input string tag, input int g);
    chk({tag, ".ctl"}, {26'd0, mem_en[g], mem_we[g], gnt0[g], gnt1[g], rv0[g], rv1[g]}, 32'd0);
    chk({tag, ".addr"}, maddr[g], 32'd0);
    chk({tag, ".wdata"}, mwdata[g], 32'd0);
    chk({tag, ".rdata0"}, rdata0[g], 32'd0);
    chk({tag, ".rdata1"}, rdata1[g], 32'd0);
  endtask

  initial begin
    clear_reqs();
    rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk_quiet("rst_outputs", g);
      chk("rst_state", {31'd0, dbg[g]}, 32'd0);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Single R0 read at RD_LAT=1.
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10;
    #1;
    chk("t1_gnt0", {31'd0, gnt0[0]}, 32'd1);
    chk("t1_gnt1", {31'd0, gnt1[0]}, 32'd0);
    chk("t1_en_we", {30'd0, mem_en[0], mem_we[0]}, 32'b10);
    chk("t1_addr", maddr[0], 32'h10);
    tick();
    r0_req = 1'b0; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_rvalid0", {31'd0, rv0[0]}, 32'd1);
    chk("t1_rdata0", rdata0[0], 32'hDEADBEEF);
    chk("t1_rvalid1", {31'd0, rv1[0]}, 32'd0);
    chk("t1_rdata1", rdata1[0], 32'd0);
    chk("t1_no_issue", {31'd0, mem_en[0]}, 32'd0);
    tick();
    mem_rdata = '0;
    #1;
    chk("t1_rvalid_pulse", {31'd0, rv0[0]}, 32'd0);

    // Both requesters writing continuously from reset.
    do_reset();
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h100; r0_wdata = 32'hA0;
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h200; r1_wdata = 32'hB1;
    #1;
    for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      chk("t2_gnt0", {31'd0, gnt0[0]}, 32'd1);
      chk("t2_gnt1", {31'd0, gnt1[0]}, 32'd0);
      chk("t2_addr", maddr[0], 32'h100);
`else
      chk("t2_gnt0", {31'd0, gnt0[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_gnt1", {31'd0, gnt1[0]}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("t2_addr", maddr[0], (i % 2 == 0) ? 32'h100 : 32'h200);
      chk("t2_wdata", mwdata[0], (i % 2 == 0) ? 32'hA0 : 32'hB1);
`endif
      chk("t2_en_we", {30'd0, mem_en[0], mem_we[0]}, 32'b11);
      tick();
    end

    // RD_LAT=3: R1 read, R0 write waits until the completion cycle.
    do_reset();
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h20;
    #1;
    chk("t3_gnt1", {31'd0, gnt1[2]}, 32'd1);
    chk("t3_addr", maddr[2], 32'h20);
    tick();
    r1_req = 1'b0;
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h30; r0_wdata = 32'h55;
    #1;
    chk("t3_blk1_gnt0", {31'd0, gnt0[2]}, 32'd0);
    chk("t3_blk1_en", {31'd0, mem_en[2]}, 32'd0);
    chk("t3_blk1_rv1", {31'd0, rv1[2]}, 32'd0);
    tick();
    chk("t3_blk2_gnt0", {31'd0, gnt0[2]}, 32'd0);
    chk("t3_blk2_rv1", {31'd0, rv1[2]}, 32'd0);
    tick();
    mem_rdata = 32'hCAFEF00D;
    #1;
    chk("t3_rv1", {31'd0, rv1[2]}, 32'd1);
    chk("t3_rdata1", rdata1[2], 32'hCAFEF00D);
    chk("t3_rv0", {31'd0, rv0[2]}, 32'd0);
    chk("t3_rdata0", rdata0[2], 32'd0);
    chk("t3_gnt0", {31'd0, gnt0[2]}, 32'd1);
    chk("t3_en_we", {30'd0, mem_en[2], mem_we[2]}, 32'b11);
    chk("t3_waddr", maddr[2], 32'h30);
    chk("t3_wdata", mwdata[2], 32'h55);
    tick();
    clear_reqs();
    #1;
    chk("t3_after_rv1", {31'd0, rv1[2]}, 32'd0);
    chk("t3_after_state", {31'd0, dbg[2]}, 32'd0);

    // RD_LAT=2: back-to-back R0 reads.
    do_reset();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h0;
    #1;
    chk("t4_gnt_a", {31'd0, gnt0[1]}, 32'd1);
    chk("t4_addr_a", maddr[1], 32'h0);
    tick();
    r0_addr = 32'h4;
    #1;
    chk("t4_wait_gnt", {31'd0, gnt0[1]}, 32'd0);
    chk("t4_wait_rv", {31'd0, rv0[1]}, 32'd0);
    chk("t4_wait_state", {31'd0, dbg[1]}, 32'd1);
    tick();
    mem_rdata = 32'h11110000;
    #1;
    chk("t4_rv_a", {31'd0, rv0[1]}, 32'd1);
    chk("t4_rdata_a", rdata0[1], 32'h11110000);
    chk("t4_gnt_b", {31'd0, gnt0[1]}, 32'd1);
    chk("t4_addr_b", maddr[1], 32'h4);
    tick();
    r0_req = 1'b0; mem_rdata = '0;
    #1;
    chk("t4_mid_rv", {31'd0, rv0[1]}, 32'd0);
    chk("t4_mid_gnt", {31'd0, gnt0[1]}, 32'd0);
    tick();
    mem_rdata = 32'h22220004;
    #1;
    chk("t4_rv_b", {31'd0, rv0[1]}, 32'd1);
    chk("t4_rdata_b", rdata0[1], 32'h22220004);
    tick();
    mem_rdata = '0;
    #1;
    chk("t4_end_rv", {31'd0, rv0[1]}, 32'd0);
    chk("t4_end_state", {31'd0, dbg[1]}, 32'd0);

    // RD_LAT=3: reset in the middle of a read abandons it.
    do_reset();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h40;
    #1;
    chk("t5_gnt0", {31'd0, gnt0[2]}, 32'd1);
    tick();
    r0_req = 1'b0; rst = 1'b1; mem_rdata = 32'h77;
    #1;
    chk_quiet("t5_in_rst", 2);
    chk("t5_in_rst_state", {31'd0, dbg[2]}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_post_rv_a", {31'd0, rv0[2]}, 32'd0);
    tick();
    chk("t5_post_rv_b", {31'd0, rv0[2]}, 32'd0);
    chk("t5_post_rdata", rdata0[2], 32'd0);
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h50;
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h60;
    #1;
    chk("t5_first_gnt0", {31'd0, gnt0[2]}, 32'd1);
    chk("t5_first_gnt1", {31'd0, gnt1[2]}, 32'd0);
    tick();
    clear_reqs();

    // Idle with no requests.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      for (int g = 0; g < 3; g++) begin
        chk_quiet("t6_idle", g);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
